// File: rtl/uart_tx_param.sv
// uart_tx_param
//   Parametrised UART transmitter fed by a small valid/ready FIFO. Frames are
//   start(0), DATA_BITS payload LSB first, optional parity, STOP_BITS stop(1).
//   Each serial bit lasts DIV = CLK_HZ/BAUD clocks; frames run back to back
//   while the FIFO holds data.
// Ports
//   clk         system clock, rising edge
//   reset_n     synchronous active-low reset
//   in_valid    producer has a word on in_data
//   in_data     word to send (DATA_BITS wide)
//   in_ready    combinational !full; accept on in_valid && in_ready
//   tx          registered serial line, idle high
//   busy        frame in progress or words queued
//   fifo_count  queued words, excluding the one on the line
module uart_tx_param #(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic [CW-1:0]        fifo_count
);

  localparam int DIV = CLK_HZ / BAUD;
  localparam int AW  = CW - 1;
  localparam int BW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int NW  = $clog2(DATA_BITS);

  localparam logic [BW-1:0] DIV_M1 = BW'(DIV - 1);
  localparam logic [NW-1:0] DB_M1  = NW'(DATA_BITS - 1);
  localparam logic [NW-1:0] SB_M1  = NW'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  generate
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (DIV < 2) begin : g_bad_div
      $error("uart_tx_param: CLK_HZ/BAUD must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  // ---------------- input FIFO ----------------
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [CW-1:0]        wr_ptr, rd_ptr;
  logic                 empty, full, push, pop;
  logic [DATA_BITS-1:0] head;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign in_ready   = !full;
  assign push       = in_valid && !full;
  assign fifo_count = wr_ptr - rd_ptr;
  assign head       = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---------------- serialiser ----------------
  logic [2:0]           state;
  logic [BW-1:0]        baud_cnt;
  logic [NW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  logic                 baud_zero;

  assign baud_zero = (baud_cnt == '0);
  // A word leaves the FIFO from IDLE, or on the edge that ends the last stop
  // bit so the next start bit follows with no idle gap.
  assign pop  = !empty && ((state == S_IDLE) ||
                (state == S_STOP && baud_zero && bit_cnt == SB_M1));
  assign busy = (state != S_IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
    end else if (pop) begin
      // Parity is taken from the word as popped, before any shifting.
      state    <= S_START;
      tx       <= 1'b0;
      baud_cnt <= DIV_M1;
      bit_cnt  <= '0;
      shreg    <= head;
      par_bit  <= (PARITY == 1) ? ~^head : ^head;
    end else if (state != S_IDLE && !baud_zero) begin
      baud_cnt <= baud_cnt - 1'b1;
    end else begin
      case (state)
        S_IDLE: ;
        S_START: begin
          state    <= S_DATA;
          tx       <= shreg[0];
          baud_cnt <= DIV_M1;
          bit_cnt  <= '0;
        end
        S_DATA: begin
          baud_cnt <= DIV_M1;
          if (bit_cnt == DB_M1) begin
            bit_cnt <= '0;
            if (PARITY != 0) begin
              state <= S_PARITY;
              tx    <= par_bit;
            end else begin
              state <= S_STOP;
              tx    <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            shreg   <= shreg >> 1;
            tx      <= shreg[1];
          end
        end
        S_PARITY: begin
          state    <= S_STOP;
          tx       <= 1'b1;
          baud_cnt <= DIV_M1;
          bit_cnt  <= '0;
        end
        S_STOP: begin
          // Expiry with an empty FIFO; the non-empty case is the pop branch.
          if (bit_cnt == SB_M1) begin
            state <= S_IDLE;
          end else begin
            bit_cnt  <= bit_cnt + 1'b1;
            baud_cnt <= DIV_M1;
          end
        end
        default: begin
          state <= S_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Four transmitters (8N1, 8E1, 8O1, 7N2; DIV=4, depth 4) share clock and
// reset. Per-instance monitors decode the line against words snooped at
// acceptance and track queue occupancy, readiness and busy.
module tb_uart_tx_param;
  localparam int CLK_HZ = 1000000;
  localparam int BAUD   = 250000;
  localparam int DIV    = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       in_valid_a [4];
  logic [8:0] in_data_a  [4];
  logic       in_ready_a [4];
  logic       tx_a       [4];
  logic       busy_a     [4];
  logic [2:0] fc_a       [4];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid_a[0]), .in_data(in_data_a[0][7:0]),
    .in_ready(in_ready_a[0]), .tx(tx_a[0]), .busy(busy_a[0]), .fifo_count(fc_a[0]));
  uart_tx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8e1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid_a[1]), .in_data(in_data_a[1][7:0]),
    .in_ready(in_ready_a[1]), .tx(tx_a[1]), .busy(busy_a[1]), .fifo_count(fc_a[1]));
  uart_tx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid_a[2]), .in_data(in_data_a[2][7:0]),
    .in_ready(in_ready_a[2]), .tx(tx_a[2]), .busy(busy_a[2]), .fifo_count(fc_a[2]));
  uart_tx_param #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7n2 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid_a[3]), .in_data(in_data_a[3][6:0]),
    .in_ready(in_ready_a[3]), .tx(tx_a[3]), .busy(busy_a[3]), .fifo_count(fc_a[3]));

  task automatic chk(input string name, input int idx, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", name, idx, cyc, act, exp);
    end
  endtask

  task automatic bound_fail(input string name, input int idx);
    vectors++;
    miscompares++;
    $display("FAIL %s[%0d] cycle %0d: bound expired", name, idx, cyc);
  endtask

  // Line monitor / scoreboard, sampled 1 time unit after each falling edge.
  // Values seen here are the ones the DUT sees at the next rising edge.
  for (genvar gi = 0; gi < 4; gi++) begin : g_mon
    localparam int DB   = (gi == 3) ? 7 : 8;
    localparam int PM   = (gi == 1) ? 2 : (gi == 2) ? 1 : 0;   // 2 even, 1 odd
    localparam int PB   = (PM != 0) ? 1 : 0;
    localparam int SB   = (gi == 3) ? 2 : 1;
    localparam int NB   = 1 + DB + PB + SB;
    localparam int FLEN = NB * DIV;

    logic [8:0]  q[$];
    int          acc = 0, started = 0, pos = 0, cnt;
    bit          pend = 0, starting;
    logic [8:0]  cur = '0;
    logic [63:0] cap = '0, expf;

    always begin
      @(negedge clk);
      #1;
      if (!reset_n) begin
        q.delete();
        acc = 0; started = 0; pos = 0; pend = 0;
      end else begin
        starting = (pos == 0) && (tx_a[gi] == 1'b0);
        if (pend) chk("no_gap_start", gi, 64'(starting), 64'd1);
        if (starting) begin
          chk("frame_has_word", gi, 64'(q.size() != 0), 64'd1);
          cur = (q.size() != 0) ? q.pop_front() : 9'd0;
          cap = '0;
          started++;
        end
        cnt = acc - started;
        chk("fifo_count", gi, 64'(fc_a[gi]), 64'(cnt));
        chk("in_ready", gi, 64'(in_ready_a[gi]), 64'(cnt < 4));
        chk("busy", gi, 64'(busy_a[gi]), 64'((pos != 0) || starting || (cnt > 0)));
        if (pos != 0 || starting) begin
          cap[pos] = tx_a[gi];
          pos++;
          if (pos == FLEN) begin
            // Expected line waveform built bit slot by bit slot from the word.
            expf = '0;
            for (int b = 0; b < NB; b++) begin
              bit v;
              if (b == 0) v = 1'b0;
              else if (b <= DB) v = cur[b-1];
              else if (PB == 1 && b == DB + 1)
                v = (PM == 2) ? ($countones(cur[DB-1:0]) % 2 == 1) : ($countones(cur[DB-1:0]) % 2 == 0);
              else v = 1'b1;
              for (int k = 0; k < DIV; k++) expf[b*DIV+k] = v;
            end
            chk("frame_waveform", gi, cap, expf);
            pos = 0;
          end
        end
        pend = (pos == 0) && (cnt > 0);
        if (in_valid_a[gi] && in_ready_a[gi]) begin
          q.push_back(in_data_a[gi]);
          acc++;
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input int idx, input logic [8:0] d, output int acc_cyc);
    int t = 0;
    in_valid_a[idx] = 1'b1;
    in_data_a[idx]  = d;
    while (!in_ready_a[idx] && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) bound_fail("accept_timeout", idx);
    @(negedge clk);
    acc_cyc = cyc;
    in_valid_a[idx] = 1'b0;
  endtask

  task automatic wait_idle(input int idx);
    int t = 0;
    while (busy_a[idx] && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) bound_fail("idle_timeout", idx);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_state();
    for (int i = 0; i < 4; i++) begin
      chk("rst_tx", i, 64'(tx_a[i]), 64'd1);
      chk("rst_busy", i, 64'(busy_a[i]), 64'd0);
      chk("rst_fifo_count", i, 64'(fc_a[i]), 64'd0);
      chk("rst_in_ready", i, 64'(in_ready_a[i]), 64'd1);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t;
    for (int i = 0; i < 4; i++) begin
      in_valid_a[i] = 1'b0;
      in_data_a[i]  = '0;
    end
    // in_valid held high through reset must not be accepted
    in_valid_a[0] = 1'b1;
    in_data_a[0]  = 9'h0AA;
    repeat (3) @(negedge clk);
    in_valid_a[0] = 1'b0;
    reset_n = 1'b1;
    #1;
    check_reset_state();
    @(negedge clk);

    // single frames on each format
    send(0, 9'h043, t);
    wait_idle(0);
    send(1, 9'h043, t);
    send(2, 9'h043, t);
    send(3, 9'h055, t);
    wait_idle(1);
    wait_idle(2);
    wait_idle(3);

    // six words held back to back, FIFO fills, then reset inside frame 2
    send(0, 9'h001, t0);
    for (int w = 2; w <= 6; w++) send(0, 9'(w), t);
    chk("sixth_accept_delay", 0, 64'(t - t0), 64'd42);
    repeat (8) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_reset_state();
    repeat (300) @(negedge clk);

    // random words and push timing on the 8N1 instance
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 60)) @(negedge clk);
      send(0, 9'($urandom_range(0, 255)), t);
    end
    wait_idle(0);

    // random words on the parity and 7N2 instances
    for (int i = 1; i < 4; i++) begin
      for (int n = 0; n < 30; n++) begin
        if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 50)) @(negedge clk);
        send(i, 9'($urandom_range(0, 511)), t);
      end
      wait_idle(i);
    end

    repeat (20) @(negedge clk);
    #1;
    chk("words_left", 0, 64'(g_mon[0].q.size()), 64'd0);
    chk("words_left", 1, 64'(g_mon[1].q.size()), 64'd0);
    chk("words_left", 2, 64'(g_mon[2].q.size()), 64'd0);
    chk("words_left", 3, 64'(g_mon[3].q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter with an input FIFO. It replaces the fixed 8N1 / 115200 baud sender and adds configurable baud divisor, data width, parity, stop bits, and a valid/ready write port. It sits between on-chip producers (test-pattern or message generators) and a PMOD TX pin. Back-to-back frames are sent with no idle gap while the FIFO holds data.

## Interface
Parameters:
- CLK_HZ, 12000000, input clock frequency in Hz
- BAUD, 115200, line rate; DIV = CLK_HZ/BAUD (integer truncation), DIV ≥ 2 required
- DATA_BITS, 8, payload bits per frame, legal 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, legal 1 or 2
- FIFO_DEPTH, 4, input FIFO entries, power of two ≥ 2

Ports (CW = $clog2(FIFO_DEPTH)+1):
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- in_valid  in  1  producer has a word on in_data
- in_data  in  DATA_BITS  word to transmit, LSB sent first
- in_ready  out  1  combinational !full; a word is accepted on an edge where in_valid && in_ready
- tx  out  1  serial line, idle high
- busy  out  1  high when state != IDLE or FIFO not empty
- fifo_count  out  CW  number of words currently queued, excluding the word in flight

## Operation
- Reset (reset_n low at an edge) sets tx=1, state=IDLE, FIFO empty, fifo_count=0, busy=0, and clears the baud and bit counters. in_ready=1 after reset.
- FIFO: circular buffer with read/write pointers of width CW, where the MSB distinguishes full from empty. Push and pop on the same edge leave the count unchanged. Writes while full are impossible because in_ready=0.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when the FIFO is non-empty, pop the head into the shift register on the next edge, set tx=0, load the baud counter, and go to START.
  - START lasts DIV cycles, then DATA.
  - DATA: DATA_BITS bits, each lasting DIV cycles, LSB first. The shift register shifts right once per bit. When the bit counter reaches DATA_BITS-1 and its period expires, go to PARITY if PARITY != 0, else STOP.
  - PARITY: one bit. Odd mode drives ~^data; even mode drives ^data. The value is computed from the word as popped.
  - STOP: STOP_BITS × DIV cycles with tx=1. At expiry, if the FIFO is non-empty, pop and drive the next start bit on the same edge (go to START). Otherwise go to IDLE.
- Bit timing: the baud counter counts DIV-1 down to 0. Every serial bit is exactly DIV clk cycles.
- Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) × DIV cycles.
- in_data bits above DATA_BITS do not exist; port width equals DATA_BITS.
- Illegal parameter values (DATA_BITS outside 5..9, PARITY = 3, STOP_BITS outside 1..2, DIV < 2) are rejected at elaboration with a generate-time error.

## Timing
- Acceptance to line: when IDLE with an empty FIFO, a word accepted at edge E drives tx=0 from edge E+1. fifo_count is 1 for the cycle after E and 0 after E+1.
- Back-to-back: no idle cycles between a stop bit and the next start bit when the FIFO is non-empty.
- in_ready falls in the cycle after the edge that makes the FIFO full. It rises in the cycle after the edge that pops from full.
- busy rises in the cycle after the first acceptance. It falls on the edge that ends the final stop bit with the FIFO empty.
- Reset mid-frame: the frame is aborted and tx=1 from the next edge. Queued words are discarded. An asserted in_valid during reset is not accepted.
- tx is registered (glitch-free). in_ready is the only combinational output.

## Test plan
- 8N1, CLK_HZ=1000000, BAUD=250000 (DIV=4): push 0x43 while idle. Expect tx for 40 cycles as 0,1,1,0,0,0,0,1,0,1 with each bit held 4 cycles, then tx=1 and busy=0.
- 8E1 then 8O1, same DIV: push 0x43 (three ones). Expect a parity bit of 1 (even) or 0 (odd) in bit slot 9, the stop bit in slot 10, and a 44-cycle frame.
- 7N2, DIV=4: push 0x55. Expect a 40-cycle frame with data 1,0,1,0,1,0,1 and two stop bits (8 high cycles) before IDLE.
- FIFO_DEPTH=4, DIV=4, 8N1: hold in_valid for six words 0x01..0x06 from idle.
  - in_ready drops after the fifth acceptance (fifo_count=4).
  - The sixth word is accepted the cycle after the first frame ends.
  - Six contiguous 40-cycle frames are sent in order with no gap.
- Same setup: assert reset_n=0 for one edge midway through word 2's data bits. Expect tx=1, fifo_count=0, busy=0, in_ready=1 next cycle, and no further frames.
- Random push timing against a reference model: 200 random words with in_valid toggling randomly. Decoded line bytes match the accepted sequence exactly, and fifo_count never exceeds 4.
